sort_result_unloader: RTL

//  Consumer end of the sorting network: snapshots the network's combinational sorted

---
 rtl/sort_result_unloader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sort_result_unloader.sv
// Snapshots the sorted lane vector on capture, then streams the top OUT_COUNT entries. First entry one clock after capture; out_* hold while !out_ready.
// Optional SORT_UNLOAD_THRESHOLD_EN: drops entries below a captured threshold and adds frame_empty.
`ifndef NETWORK_WIDTH
`define NETWORK_WIDTH 16
`endif
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 8
`endif

module sort_result_unloader #(
   parameter int SIZE      = 8,
   parameter int OUT_COUNT = 4,
   parameter int FROM_TOP  = 1
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic [SIZE-1:0][`NETWORK_WIDTH-1:0]         sorted_data,
   input  logic [SIZE-1:0][`INDEX_WIDTH-1:0]           sorted_index,
   input  logic                                        capture,
`ifdef SORT_UNLOAD_THRESHOLD_EN
   input  logic [`NETWORK_WIDTH-1:0]                   threshold,
   output logic                                        frame_empty,
`endif
   output logic                                        busy,
   output logic                                        capture_drop,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [`NETWORK_WIDTH-1:0]                   out_data,
   output logic [`INDEX_WIDTH-1:0]                     out_index,
   output logic [((SIZE > 1) ? $clog2(SIZE) : 1)-1:0]  out_rank,
   output logic                                        out_last
);

   localparam int RW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [RW-1:0] LAST_RANK = RW'(OUT_COUNT - 1);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                                state, state_nxt;
   logic [RW-1:0]                         rank, rank_nxt;
   logic [SIZE-1:0][`NETWORK_WIDTH-1:0]   snap_data;
   logic [SIZE-1:0][`INDEX_WIDTH-1:0]     snap_index;
   logic                                  load;
   logic                                  drop_nxt;
   logic                                  last_entry;
   logic [RW-1:0]                         lane;

   function automatic logic [RW-1:0] lane_of(input logic [RW-1:0] k);
      return (FROM_TOP != 0) ? (RW'(SIZE - 1) - k) : k;
   endfunction

   assign lane = lane_of(rank);

`ifdef SORT_UNLOAD_THRESHOLD_EN
   logic [`NETWORK_WIDTH-1:0] snap_thr;
   logic                      first_ok;
   logic                      empty_nxt;
   logic [RW-1:0]             rank_inc;

   assign first_ok = sorted_data[lane_of('0)] >= threshold;
   assign rank_inc = rank + 1'b1;
   // Data is sorted in stream order, so the first failing successor ends the frame.
   assign last_entry = (rank == LAST_RANK) || (snap_data[lane_of(rank_inc)] < snap_thr);
`else
   assign last_entry = (rank == LAST_RANK);
`endif

   always_comb begin
      state_nxt = state;
      rank_nxt  = rank;
      load      = 1'b0;
      drop_nxt  = 1'b0;
`ifdef SORT_UNLOAD_THRESHOLD_EN
      empty_nxt = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (capture) begin
               load     = 1'b1;
               rank_nxt = '0;
`ifdef SORT_UNLOAD_THRESHOLD_EN
               if (first_ok) state_nxt = STREAM;
               else          empty_nxt = 1'b1;
`else
               state_nxt = STREAM;
`endif
            end
         end
         STREAM: begin
            drop_nxt = capture;
            if (out_ready) begin
               if (last_entry) begin
                  state_nxt = IDLE;
                  rank_nxt  = '0;
               end else begin
                  rank_nxt = rank + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rank         <= '0;
         snap_data    <= '0;
         snap_index   <= '0;
         capture_drop <= 1'b0;
`ifdef SORT_UNLOAD_THRESHOLD_EN
         snap_thr     <= '0;
         frame_empty  <= 1'b0;
`endif
      end else begin
         state        <= state_nxt;
         rank         <= rank_nxt;
         capture_drop <= drop_nxt;
         if (load) begin
            snap_data  <= sorted_data;
            snap_index <= sorted_index;
         end
`ifdef SORT_UNLOAD_THRESHOLD_EN
         if (load) snap_thr <= threshold;
         frame_empty <= empty_nxt;
`endif
      end
   end

   // Outputs read straight from the snapshot, so they stay stable under backpressure.
   assign out_valid = (state == STREAM);
   assign busy      = out_valid;
   assign out_rank  = rank;
   assign out_last  = out_valid & last_entry;
   assign out_data  = out_valid ? snap_data[lane]  : '0;
   assign out_index = out_valid ? snap_index[lane] : '0;

endmodule
